// File: rtl/led_breath_pwm.sv
// Breathing-LED PWM: free-running PWM whose duty ramps up, holds, ramps down, holds.
// Define LED_BREATH_GAMMA_EN to drive the PWM from (level*level) >> PWM_W instead of level.
module led_breath_pwm #(
    parameter int PWM_W        = 8,
    parameter int STEP_DIV     = 64,
    parameter int HOLD_PERIODS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             led,
    output logic [PWM_W-1:0] level,
    output logic [1:0]       phase,
    output logic             period_strobe
);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } phase_t;

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [PWM_W-1:0]  CNT_MAX      = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]  LEVEL_MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]  LEVEL_NEAR   = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [PWM_W-1:0]  LEVEL_ONE    = PWM_W'(1);

    phase_t              state;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [PWM_W-1:0]    duty_q;
    logic [PWM_W-1:0]    duty_src;
    logic [STEP_W-1:0]   step_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_W-1:0]  level_sq;
    assign level_sq = {{PWM_W{1'b0}}, level} * {{PWM_W{1'b0}}, level};
    assign duty_src = PWM_W'(level_sq >> PWM_W);
`else
    assign duty_src = level;
`endif

    assign period_strobe = en && (pwm_cnt == CNT_MAX);
    assign phase         = state;

    // The strobe edge is also the wrap edge, so duty and the ramp FSM both advance there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            duty_q   <= '0;
            level    <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            state    <= UP;
            led      <= 1'b0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            led     <= (pwm_cnt < duty_q);
            if (period_strobe) begin
                duty_q <= duty_src;
                case (state)
                    UP: begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (level != LEVEL_MAX) begin
                                level <= level + PWM_W'(1);
                                if (level == LEVEL_NEAR) begin
                                    state    <= HOLD_HI;
                                    hold_cnt <= '0;
                                end
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            step_cnt <= '0;
                            state    <= DOWN;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    DOWN: begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (level != '0) begin
                                level <= level - PWM_W'(1);
                                if (level == LEVEL_ONE) begin
                                    state    <= HOLD_LO;
                                    hold_cnt <= '0;
                                end
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end
                    HOLD_LO: begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            step_cnt <= '0;
                            state    <= UP;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                endcase
            end
        end else begin
            led <= 1'b0;
        end
    end

endmodule
